pc_3gpp_alpha_ram_ctrl: RTL

Layer sequencer for the polar decoder's alpha (LLR) RAM. One start command runs one layer pass: it issues a burst of RAM read addresses, flags when the read data reaches the f/g calculation unit, and generates write strobes, addresses and half-select aligned to the unit's output. The block sits between the decoder's top-level scheduler and the alpha RAM / f-g datapath, and hides the RAM read latency and calculation latency from the scheduler.

---
 rtl/pc_3gpp_alpha_ram_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/pc_3gpp_alpha_ram_ctrl.sv
// Alpha RAM layer sequencer: bursts 2^ilen_log reads, then writes results back in pairs (low/high half).
// Read at +1, ordval at +2+pPIPE, write at +1+cLAT after start; iclkena=0 freezes everything, istart ignored while busy.
module pc_3gpp_alpha_ram_ctrl #(
  parameter int pADDR_W   = 8,
  parameter int pPIPE     = 0,
  parameter int pCALC_LAT = 1
) (
  input  logic                               iclk,
  input  logic                               ireset,
  input  logic                               iclkena,
  input  logic                               istart,
  input  logic [$clog2(pADDR_W+1)-1:0]       ilen_log,
  input  logic [pADDR_W-1:0]                 ibase_raddr,
  input  logic [pADDR_W-1:0]                 ibase_waddr,
  output logic                               oread,
  output logic [pADDR_W-1:0]                 oraddr,
  output logic                               ordval,
  output logic                               owrite,
  output logic [pADDR_W-1:0]                 owaddr,
  output logic                               owsel,
  output logic                               obusy,
  output logic                               odone
);

  localparam int cLAT = 1 + pPIPE + pCALC_LAT;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  // r_pv[0] is the read-issue stage; r_pv[cLAT] is the write stage
  logic [cLAT:0]      r_pv;
  logic [pADDR_W-1:0] r_pk [0:cLAT-1];
  logic [pADDR_W-1:0] r_last;
  logic [pADDR_W-1:0] r_raddr;
  logic [pADDR_W-1:0] r_wbase;
  logic [pADDR_W-1:0] r_waddr;
  logic               r_wsel;
  logic               r_done;
  logic [pADDR_W-1:0] w_last;

  // N-1 as a mask; ilen_log == pADDR_W shifts everything out and gives all ones
  assign w_last = ~({pADDR_W{1'b1}} << ilen_log);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (istart) w_state_nxt = READ;
      READ:    if (r_pk[0] == r_last) w_state_nxt = DRAIN;
      DRAIN:   if (r_pv[cLAT-1:0] == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state <= IDLE;
      r_pv    <= '0;
      for (int d = 0; d < cLAT; d++) r_pk[d] <= '0;
      r_last  <= '0;
      r_raddr <= '0;
      r_wbase <= '0;
      r_waddr <= '0;
      r_wsel  <= 1'b0;
      r_done  <= 1'b0;
    end else if (iclkena) begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == DRAIN) && (w_state_nxt == IDLE);
      for (int d = 1; d <= cLAT; d++) r_pv[d] <= r_pv[d-1];
      for (int d = 1; d < cLAT; d++)  r_pk[d] <= r_pk[d-1];
      if (r_pv[cLAT-1]) r_waddr <= r_wbase + (r_pk[cLAT-1] >> 1);
      r_wsel <= r_pv[cLAT-1] & r_pk[cLAT-1][0];
      case (r_state)
        IDLE: begin
          if (istart) begin
            r_pv[0] <= 1'b1;
            r_pk[0] <= '0;
            r_raddr <= ibase_raddr;
            r_wbase <= ibase_waddr;
            r_last  <= w_last;
          end
        end
        READ: begin
          if (r_pk[0] == r_last) begin
            r_pv[0] <= 1'b0;
          end else begin
            r_pk[0] <= r_pk[0] + pADDR_W'(1);
            r_raddr <= r_raddr + pADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign oread  = r_pv[0];
  assign oraddr = r_raddr;
  assign ordval = r_pv[1+pPIPE];
  assign owrite = r_pv[cLAT];
  assign owaddr = r_waddr;
  assign owsel  = r_wsel;
  assign obusy  = (r_state != IDLE);
  assign odone  = r_done;

endmodule
